sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer for the shared 16-bit asynchronous SRAM bus (CE/UB/LB/OE/WE active-low, 20-bit ADDR, bidirectional Data).
- Port 0 is the slc3 processor. Port 1 is a secondary master, such as a loader or debug DMA.
- Grants one single-word access at a time.
- Generates SRAM strobe timing with a programmable wait count, latches read data, and returns a one-cycle ack to the granted requester.

Parameters:
- WAIT_CYCLES, 1: cycles, minus one, that the SRAM strobes are held active; access phase lasts WAIT_CYCLES+1 cycles; legal range 0..15.
- ADDR_W, 20: SRAM address width.
- DATA_W, 16: SRAM data width.

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 access request, level, held until ack0
- we0  in  1  port 0: 1=write, 0=read; stable while req0
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- rdata0  out  DATA_W  port 0 read data, valid with ack0
- ack0  out  1  port 0 completion pulse, one cycle
- req1, we1, addr1, wdata1, rdata1, ack1  as port 0, for port 1
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low
- ADDR  out  ADDR_W  SRAM address
- Data  inout  DATA_W  SRAM data bus; driven only during write phases, else Z

Behaviour:
- Clock is Clk; reset is Reset, asynchronous and active-high.
- Reset values:
  - CE=UB=LB=OE=WE=1, ADDR=0, Data=Z
  - ack0=ack1=0, rdata0=rdata1=0
  - state=IDLE, last_grant=1, so port 0 wins the first tie
- Reset asserted mid-access aborts immediately: WE and OE return high and Data is released asynchronously. No ack is issued.
- FSM states: IDLE, RD, WR, WR_HOLD, ACK.
- IDLE:
  - All strobes high, Data=Z.
  - If any req is high, latch the grant, that port's we/addr/wdata, and reset the wait counter.
  - Go to RD or WR.
- Arbitration: fixed priority, port 0 over port 1 (see Optional Feature).
  - Requests are sampled only in IDLE.
  - A request arriving mid-access waits.
- RD:
  - CE=0, OE=0, WE=1, UB=LB=0, ADDR=latched address, Data=Z.
  - Hold for WAIT_CYCLES+1 cycles.
  - On the final cycle, capture Data into the granted port's rdata register, then go to ACK.
  - The other port's rdata is unchanged.
- WR:
  - CE=0, WE=0, OE=1, UB=LB=0, ADDR and Data driven with latched values.
  - Hold for WAIT_CYCLES+1 cycles, then go to WR_HOLD.
- WR_HOLD:
  - One cycle with WE=1, CE=0, ADDR and Data still driven (data hold), then go to ACK.
- ACK:
  - Strobes high, Data=Z.
  - ack of the granted port is 1 for exactly this cycle; update last_grant; go to IDLE.
- Latency, request seen in IDLE at cycle t:
  - Read: ack at t+WAIT_CYCLES+2.
  - Write: ack at t+WAIT_CYCLES+3.
  - With default WAIT_CYCLES=1: read ack at t+3, write ack at t+4.
- Requesters must drop req in the cycle after ack. A req still high in the IDLE following ACK is treated as a new request.
- ack0 and ack1 are never high together. Data is never driven while OE=0.
- Address and write data are latched at grant, so requester changes mid-access have no effect.

Optional Feature:
- SRAM_ARB_RR_EN defined: round-robin arbitration. On simultaneous req0 and req1 in IDLE, grant the port that is not last_grant. A single requester is always granted.
- Undefined: fixed priority, port 0 always wins ties. last_grant is still maintained but ignored.

Test Plan:
- Port 0 read, WAIT_CYCLES=1: SRAM model holds 0x3A5C at addr 0x00010, req0 at t -> OE=0/CE=0 for 2 cycles with ADDR=0x00010, ack0 at t+3, rdata0=0x3A5C, rdata1 unchanged.
- Port 1 write 0xBEEF to 0x00FFF -> WE low for 2 cycles, then 1 hold cycle with Data=0xBEEF, ack1 at t+4; a later port 0 read of 0x00FFF returns 0xBEEF.
- req0 and req1 both held high continuously, two accesses each:
  - RR undefined: grant order 0,0 then 1,1.
  - SRAM_ARB_RR_EN: order 0,1,0,1.
- req1 raised during a port 0 write -> port 1 starts only after ack0. Data is Z in the RD and ACK states, and ack0 and ack1 never overlap.
- Reset asserted in the second WR cycle -> WE=1, Data=Z in the same cycle, no ack. After release, a fresh port 0 read completes normally.
- WAIT_CYCLES=0: read ack at t+2, write ack at t+3. WAIT_CYCLES=15: OE low for exactly 16 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for a shared async 16-bit SRAM.
// Define SRAM_ARB_RR_EN for round-robin tie-break; default is port 0 priority.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, ACK} state_t;

    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic              grant;
    logic              last_grant;
    logic              pick;
    logic [DATA_W-1:0] dout;
    logic              dout_en;

    always_comb begin
        pick = ~req0;
`ifdef SRAM_ARB_RR_EN
        if (req0 && req1)
            pick = ~last_grant;
`endif
    end

    assign Data = dout_en ? dout : 'z;

    // Strobes and the data driver are registers so reset releases them at once
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            CE         <= 1'b1;
            UB         <= 1'b1;
            LB         <= 1'b1;
            OE         <= 1'b1;
            WE         <= 1'b1;
            ADDR       <= '0;
            dout       <= '0;
            dout_en    <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant <= pick;
                        cnt   <= '0;
                        CE    <= 1'b0;
                        UB    <= 1'b0;
                        LB    <= 1'b0;
                        ADDR  <= pick ? addr1 : addr0;
                        dout  <= pick ? wdata1 : wdata0;
                        if (pick ? we1 : we0) begin
                            WE      <= 1'b0;
                            dout_en <= 1'b1;
                            state   <= WR;
                        end else begin
                            OE    <= 1'b0;
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt == WLAST) begin
                        if (grant)
                            rdata1 <= Data;
                        else
                            rdata0 <= Data;
                        {CE, UB, LB, OE} <= '1;
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= ACK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WR: begin
                    if (cnt == WLAST) begin
                        WE    <= 1'b1;
                        state <= WR_HOLD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WR_HOLD: begin
                    {CE, UB, LB} <= '1;
                    dout_en <= 1'b0;
                    ack0    <= ~grant;
                    ack1    <= grant;
                    state   <= ACK;
                end
                ACK: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM model.
// Extra instances cover WAIT_CYCLES=0 and WAIT_CYCLES=15.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [19:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic [15:0] rdata0, rdata1;
    logic        ack0, ack1;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sram_arbiter #(.WAIT_CYCLES(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .ack1(ack1),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data(Data)
    );

    // SRAM model: 4K words, preloaded on the first clock
    logic [15:0] mem [0:4095];
    bit          loaded = 1'b0;

    assign Data = (!CE && !OE && WE) ? mem[ADDR[11:0]] : 'z;

    always @(negedge Clk) begin
        if (!loaded) begin
            mem[12'h010] <= 16'h3A5C;
            mem[12'h007] <= 16'hA5A5;
            mem[12'h000] <= 16'h0000;
            loaded       <= 1'b1;
        end else if (!CE && !WE) begin
            mem[ADDR[11:0]] <= Data;
        end
    end

    // Bus monitor
    int          oe_lo = 0, we_lo = 0, hold_n = 0, overlap = 0, both_lo = 0;
    logic [15:0] hold_data = '0;
    logic [19:0] addr_seen = '0;

    always @(negedge Clk) begin
        if (!OE) oe_lo <= oe_lo + 1;
        if (!WE) we_lo <= we_lo + 1;
        if (!CE && WE && OE) begin
            hold_n    <= hold_n + 1;
            hold_data <= Data;
        end
        if (!CE) addr_seen <= ADDR;
        if (ack0 && ack1) overlap <= overlap + 1;
        if (!OE && !WE) both_lo <= both_lo + 1;
    end

    // Secondary instances share port-0 stimulus
    logic        xreq = 1'b0, xwe = 1'b0;
    logic [15:0] rdata_w0, rdata_w15, rd1_w0, rd1_w15;
    logic        ack_w0, ack_w15, a1_w0, a1_w15;
    logic        ce_w0, ub_w0, lb_w0, oe_w0, we_w0;
    logic        ce_w15, ub_w15, lb_w15, oe_w15, we_w15;
    logic [19:0] ad_w0, ad_w15;
    wire  [15:0] d_w0, d_w15;

    assign d_w0  = !oe_w0  ? 16'hC0DE : 'z;
    assign d_w15 = !oe_w15 ? 16'hC0DE : 'z;

    sram_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
        .Clk(Clk), .Reset(Reset),
        .req0(xreq), .we0(xwe), .addr0(20'h5), .wdata0(16'h9999),
        .rdata0(rdata_w0), .ack0(ack_w0),
        .req1(1'b0), .we1(1'b0), .addr1(20'h0), .wdata1(16'h0),
        .rdata1(rd1_w0), .ack1(a1_w0),
        .CE(ce_w0), .UB(ub_w0), .LB(lb_w0), .OE(oe_w0), .WE(we_w0),
        .ADDR(ad_w0), .Data(d_w0)
    );

    sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
        .Clk(Clk), .Reset(Reset),
        .req0(xreq), .we0(xwe), .addr0(20'h5), .wdata0(16'h9999),
        .rdata0(rdata_w15), .ack0(ack_w15),
        .req1(1'b0), .we1(1'b0), .addr1(20'h0), .wdata1(16'h0),
        .rdata1(rd1_w15), .ack1(a1_w15),
        .CE(ce_w15), .UB(ub_w15), .LB(lb_w15), .OE(oe_w15), .WE(we_w15),
        .ADDR(ad_w15), .Data(d_w15)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    // One access on the main instance, started from IDLE
    task automatic access(input bit port, input bit wr, input logic [19:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd,
                          input int exp_lat, input string nm);
        int          lat;
        int          oe_s, we_s, h_s;
        logic [15:0] other;
        oe_s  = oe_lo;
        we_s  = we_lo;
        h_s   = hold_n;
        other = port ? rdata0 : rdata1;
        if (port) begin
            req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = wd;
        end else begin
            req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = wd;
        end
        lat = 0;
        while (lat < 40) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            if (ack0 || ack1) break;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " ack port"}, {ack1, ack0}, port ? 2'b10 : 2'b01);
        chk({nm, " addr"}, addr_seen, a);
        if (wr) begin
            chk({nm, " we low cycles"}, we_lo - we_s, 2);
            chk({nm, " hold cycles"}, hold_n - h_s, 1);
            chk({nm, " hold data"}, hold_data, wd);
        end else begin
            chk({nm, " oe low cycles"}, oe_lo - oe_s, 2);
            chk({nm, " rdata"}, port ? rdata1 : rdata0, exp_rd);
        end
        chk({nm, " other rdata"}, port ? rdata0 : rdata1, other);
        @(negedge Clk);
    endtask

    task automatic side(input bit wr, input int exp0, input int exp15);
        int n, l0, l15, s15;
        n = 0; l0 = 0; l15 = 0; s15 = 0;
        xwe  = wr;
        xreq = 1'b1;
        while (n < 60 && l15 == 0) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (ack_w0 && l0 == 0) begin
                l0   = n;
                xreq = 1'b0;
            end
            if (wr ? !we_w15 : !oe_w15) s15++;
            if (ack_w15) l15 = n;
        end
        xreq = 1'b0;
        chk(wr ? "w0 write lat" : "w0 read lat", l0, exp0);
        chk(wr ? "w15 write lat" : "w15 read lat", l15, exp15);
        chk(wr ? "w15 we low" : "w15 oe low", s15, 16);
        if (!wr) begin
            chk("w0 rdata", rdata_w0, 16'hC0DE);
            chk("w15 rdata", rdata_w15, 16'hC0DE);
        end
        @(negedge Clk);
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [19:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int c, c0, c1;
        int order[$];
        int exp_order[4];
        int rem0, rem1;

        tbl[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h3A5C, 3};
        tbl[1] = '{1'b1, 1'b1, 20'h00FFF, 16'hBEEF, 16'h0000, 4};
        tbl[2] = '{1'b0, 1'b0, 20'h00FFF, 16'h0000, 16'hBEEF, 3};
        tbl[3] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'h3A5C, 3};
        tbl[4] = '{1'b0, 1'b1, 20'h00123, 16'h1111, 16'h0000, 4};
        tbl[5] = '{1'b1, 1'b0, 20'h00123, 16'h0000, 16'h1111, 3};
        tbl[6] = '{1'b0, 1'b0, 20'h00007, 16'h0000, 16'hA5A5, 3};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        chk("reset addr", ADDR, 20'h0);
        chk("reset acks", {ack0, ack1}, 2'b00);
        chk("reset rdata", {rdata0, rdata1}, 32'h0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 7; i++)
            access(tbl[i].port, tbl[i].wr, tbl[i].a, tbl[i].wd,
                   tbl[i].rd, tbl[i].lat, $sformatf("v%0d", i));

        // Port 1 request arrives during a port 0 write
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h20; wdata0 = 16'h5555;
        @(posedge Clk);
        @(negedge Clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h20;
        c = 1; c0 = 0; c1 = 0;
        while (c < 40 && c1 == 0) begin
            @(posedge Clk);
            c++;
            @(negedge Clk);
            if (ack0) begin c0 = c; req0 = 1'b0; end
            if (ack1) begin c1 = c; req1 = 1'b0; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("mid ack0 cycle", c0, 4);
        chk("mid ack1 after ack0", c1 - c0, 4);
        chk("mid rdata1", rdata1, 16'h5555);
        @(negedge Clk);

        // Reset during the second write cycle
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h30; wdata0 = 16'h7777;
        @(posedge Clk);
        @(posedge Clk);
        #2;
        chk("abort pre WE", WE, 1'b0);
        Reset = 1'b1;
        #1;
        chk("abort WE OE CE", {WE, OE, CE}, 3'b111);
        chk("abort ack", {ack0, ack1}, 2'b00);
        req0 = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("abort no ack", {ack0, ack1}, 2'b00);
        Reset = 1'b0;
        @(negedge Clk);
        access(1'b0, 1'b0, 20'h00010, 16'h0, 16'h3A5C, 3, "post abort");

        // Both ports hold requests for two accesses each
        do_reset();
`ifdef SRAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        rem0 = 2; rem1 = 2;
        we0 = 1'b0; addr0 = 20'h10; we1 = 1'b0; addr1 = 20'hFFF;
        req0 = 1'b1; req1 = 1'b1;
        c = 0;
        while (c < 80 && order.size() < 4) begin
            @(posedge Clk);
            c++;
            @(negedge Clk);
            if (ack0) begin
                order.push_back(0); rem0--; req0 = 1'b0;
            end else if (!req0 && rem0 > 0) begin
                req0 = 1'b1;
            end
            if (ack1) begin
                order.push_back(1); rem1--; req1 = 1'b0;
            end else if (!req1 && rem1 > 0) begin
                req1 = 1'b1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("tie grants", order.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie order %0d", i),
                (i < order.size()) ? order[i] : -1, exp_order[i]);
        @(negedge Clk);

        side(1'b0, 2, 17);
        side(1'b1, 3, 18);

        chk("ack overlap", overlap, 0);
        chk("oe and we low", both_lo, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
